// File: rtl/qq_seq_pkg.sv
// qq_seq_pkg: shared state encoding and default widths for the Q-switch step sequencer
package qq_seq_pkg;
  localparam int CNT_W = 5;
  localparam int PER_W = 16;
  localparam int REP_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/qq_tick_gen.sv
// qq_tick_gen: dwell counter that strobes tick on the last cycle of each step period
module qq_tick_gen #(
  parameter int PER_W = qq_seq_pkg::PER_W
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  output logic             tick
);
  logic [PER_W-1:0] cnt;
  assign tick = enable && cnt == period - 1'b1;
  always_ff @(posedge clk_sys)
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/qq_seq_counter.sv
// qq_seq_counter: step sequencer sweeping count 0..step_last with programmable dwell and repeat
module qq_seq_counter #(
  parameter int CNT_W = qq_seq_pkg::CNT_W,
  parameter int PER_W = qq_seq_pkg::PER_W,
  parameter int REP_W = qq_seq_pkg::REP_W
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] step_period,
  input  logic [CNT_W-1:0] step_last,
  input  logic [REP_W-1:0] rep_num,
  output logic [CNT_W-1:0] count,
  output logic             state_start,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  import qq_seq_pkg::*;
  state_t state, state_n;
  logic [PER_W-1:0] per_q;
  logic [CNT_W-1:0] last_q, count_n;
  logic [REP_W-1:0] rep_q, rep_cnt, rep_n;
  logic load, tick, wrap;
  assign busy = state != IDLE;
  assign load = state == IDLE && start && !stop;
  assign wrap = tick && count == last_q;
  qq_tick_gen #(.PER_W(PER_W)) u_tick (
    .clk_sys(clk_sys),
    .rst(rst),
    .clear(state != RUN),
    .enable(state == RUN),
    .period(per_q),
    .tick(tick)
  );
  always_comb begin
    state_n = IDLE;
    count_n = '0;
    rep_n   = load ? '0 : rep_cnt;
    if (load) state_n = RUN;
    if (state == RUN && !stop) begin
      state_n = wrap && rep_cnt == rep_q - 1'b1 ? DONE : RUN;
      count_n = wrap ? '0 : count + CNT_W'(tick);
      rep_n   = wrap ? rep_cnt + 1'b1 : rep_cnt;
    end
  end
  always_ff @(posedge clk_sys)
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      state_start <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      per_q       <= '0;
      last_q      <= '0;
      rep_q       <= '0;
      rep_cnt     <= '0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      rep_cnt     <= rep_n;
      state_start <= state_n == RUN;
      done        <= state_n == DONE;
      aborted     <= state == RUN && stop;
      if (load) begin
        per_q  <= step_period == '0 ? PER_W'(1) : step_period;
        last_q <= step_last;
        rep_q  <= rep_num == '0 ? REP_W'(1) : rep_num;
      end
    end
endmodule

// File: tb/tb_qq_seq_counter.sv
// tb_qq_seq_counter: scoreboard bench checking every cycle of qq_seq_counter against expected outputs
module tb_qq_seq_counter;
  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] step_period = '0;
  logic [4:0]  step_last = '0;
  logic [7:0]  rep_num = '0;
  logic [4:0]  count;
  logic        state_start, busy, done, aborted;
  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  bit mon_on = 1'b1;
  qq_seq_counter dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .start(start),
    .stop(stop),
    .step_period(step_period),
    .step_last(step_last),
    .rep_num(rep_num),
    .count(count),
    .state_start(state_start),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys)
    if (mon_on) begin
      logic [8:0] got, want;
      got  = {count, state_start, busy, done, aborted};
      want = '0;
      if (q.size() > 0 && q[0].cyc == cyc) want = q.pop_front().v;
      vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL monitor cyc=%0d got count=%0d ss=%b busy=%b done=%b ab=%b want count=%0d ss=%b busy=%b done=%b ab=%b",
                 cyc, got[8:4], got[3], got[2], got[1], got[0], want[8:4], want[3], want[2], want[1], want[0]);
      end
    end
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic push(input int c, input logic [4:0] cnt, input logic ss, input logic bz, input logic dn, input logic ab);
    q.push_back('{c, {cnt, ss, bz, dn, ab}});
  endtask
  task automatic run(input int p, input int l, input int r, input int mode, input int cut);
    int pe, re, n, nrun, c0;
    pe = p == 0 ? 1 : p;
    re = r == 0 ? 1 : r;
    n = pe * (l + 1) * re;
    nrun = (mode == 1 || mode == 2) ? cut + 1 : n;
    step_period = 16'(p);
    step_last = 5'(l);
    rep_num = 8'(r);
    start = 1'b1;
    c0 = cyc;
    for (int j = 0; j < nrun; j++) push(c0 + 1 + j, 5'((j / pe) % (l + 1)), 1'b1, 1'b1, 1'b0, 1'b0);
    if (mode == 0 || mode == 3) push(c0 + 1 + n, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    if (mode == 1) push(c0 + 1 + nrun, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    if (mode == 3)
      for (int j = 0; j < n; j++) begin
        step_period = 16'($urandom_range(0, 20));
        step_last = 5'($urandom_range(0, 31));
        rep_num = 8'($urandom_range(0, 9));
        start = 1'($urandom_range(0, 1));
        tick();
      end
    start = 1'b0;
    if (mode == 1 || mode == 2) begin
      repeat (cut) tick();
      if (mode == 1) stop = 1'b1;
      else rst = 1'b1;
      tick();
      stop = 1'b0;
      rst = 1'b0;
    end
    while (cyc < c0 + n + 4) tick();
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    run(3, 2, 1, 0, 0);
    run(1, 0, 3, 0, 0);
    run(0, 1, 0, 0, 0);
    step_period = 16'd2;
    step_last = 5'd1;
    rep_num = 8'd1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL start+stop: busy=%b", busy);
    end
    vecs++;
    if (state_start !== 1'b0) begin
      errs++;
      $display("FAIL start+stop: state_start=%b", state_start);
    end
    vecs++;
    if (count !== 5'd0) begin
      errs++;
      $display("FAIL start+stop: count=%0d", count);
    end
    repeat (4) tick();
    run(4, 5, 2, 1, 38);
    run(2, 3, 2, 3, 0);
    run(3, 2, 2, 2, 10);
    run(2, 1, 1, 0, 0);
    run(5, 31, 1, 0, 0);
    repeat (2) tick();
    mon_on = 1'b0;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      errs++;
      $display("FAIL leftover cyc=%0d expected entry never compared, want=%h", e.cyc, e.v);
    end
    if (errs == 0) $display("PASS");
    else $display("FAIL");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
